mem_dbus_if: RTL and testbench
==============================

// Module: mem_dbus_if
// PURPOSE
// - MEM-stage load/store unit of the OpenMIPS pipeline; consumes the EX/MEM pipeline register outputs.
// - Decodes aluop/address/reg2 and issues byte-lane-qualified req/ack transactions to the data RAM.
// - Holds the pipeline via stallreq_o until ack; returns the write-back triple with extended load data.
// - Big-endian, 32-bit bus; byte addr[1:0]=00 is the MSB lane.
// PARAMETERS
// - ADDR_W  32  data bus address width (byte address)
// - TO_MAX  255 wait cycles without ack before abandoning the access (0 = never)
// PORTS
// - clk           in   1   clock
// - rst           in   1   reset, synchronous, active-high
// - stall         in   6   ctrl stall vector; stall[4]=Stop means MEM/WB is held
// - wd_i          in   5   destination register address
// - wreg_i        in   1   register write enable
// - wdata_i       in   32  ALU result (non-memory instructions)
// - aluop_i       in   8   operation subtype (EXE_LB_OP..EXE_SW_OP)
// - mem_addr_i    in   32  effective address
// - reg2_i        in   32  store data
// - wd_o          out  5   to MEM/WB: destination address
// - wreg_o        out  1   to MEM/WB: write enable
// - wdata_o       out  32  to MEM/WB: result / extended load data
// - stallreq_o    out  1   to ctrl: hold pipeline, access in flight
// - dbus_req_o    out  1   bus request, registered
// - dbus_we_o     out  1   1=store, registered
// - dbus_addr_o   out  32  word address {addr[31:2],2'b00}, registered
// - dbus_sel_o    out  4   byte enables, [3]=addr 00, registered
// - dbus_wdata_o  out  32  store data, lane-replicated, registered
// - dbus_rdata_i  in   32  load data, valid when dbus_ack_i=1
// - dbus_ack_i    in   1   one-cycle completion strobe
// - err_o         out  1   pulse: misaligned access or timeout
// BEHAVIOUR
// - Reset: state IDLE; all dbus_* outputs, err_o, stallreq_o, wd_o, wreg_o, wdata_o = 0; timeout counter = 0.
// - Memory op = aluop_i in {LB,LBU,LH,LHU,LW,SB,SH,SW}; any other aluop passes wd/wreg/wdata straight through, stallreq_o=0.
// - FSM:
//   - IDLE: memory op and aligned -> stallreq_o=1 (combinational); at the edge load dbus_* with req=1 -> BUSY.
//   - BUSY: dbus_* held stable; stallreq_o=1 until ack.
//     - On the ack cycle: stallreq_o=0, req cleared at the edge, rdata captured into rbuf.
//     - Then stall[4]=Stop -> HOLD, else -> IDLE.
//   - HOLD: stallreq_o=0, no re-issue, wdata_o from rbuf; stall[4]=NoStop -> IDLE.
// - Latency: min 2 cycles in MEM (issue cycle + ack cycle). Each extra wait cycle adds 1.
// - Lanes/sel by addr[1:0]:
//   - byte ops: 00->1000, 01->0100, 10->0010, 11->0001.
//   - half ops: addr[1]=0 -> 1100, else 0011.
//   - word ops: 1111.
// - Store data: SB {4{b}}, SH {2{h}}, SW reg2.
// - Load data: LB/LH sign-extend, LBU/LHU zero-extend the selected lane; LW whole word. Source is dbus_rdata_i in the ack cycle, rbuf in HOLD.
// - Misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0): no request, err_o pulse, wreg_o=0, stallreq_o=0.
// - Timeout: counter runs in BUSY; at TO_MAX: drop req, err_o pulse, wreg_o=0, -> IDLE.
// - Ack received in IDLE/HOLD: ignored.
// - Ack in the same cycle the request is first driven: legal, counts as completion.
// - Reset mid-access: req dropped at the reset edge, FSM -> IDLE; a late ack is ignored.
// - Store: wreg_o=0 in all states, regardless of wreg_i.
// STRUCTURE
// - Constants (aluop codes, Stop/NoStop, ZeroWord, RegBus widths) live in shared defines.v; add MEM_IDLE/MEM_BUSY/MEM_HOLD there.
// - Sub-module mem_lane_align (combinational): decodes aluop+addr -> sel, store data, load extraction, misaligned flag. Used for both issue and return paths.
// TESTING
// - LW addr 0x100, ack after 0 waits, rdata 0x12345678 -> sel 1111, stallreq 1 cycle, wdata_o 0x12345678.
// - LB addr 0x103, rdata 0x000000F0 -> sel 0001, wdata_o 0xFFFFFFF0; LBU same -> 0x000000F0.
// - SH addr 0x102, reg2 0xAAAA5678 -> sel 0011, dbus_wdata 0x56785678, we=1, wreg_o=0.
// - LW with 3 wait cycles, stall[4]=Stop 2 cycles after ack -> stallreq 4 cycles, HOLD 2 cycles, single req, wdata_o from rbuf.
// - LW addr 0x101 -> no req, err_o pulse, wreg_o=0. TO_MAX=4 with no ack -> req dropped after 4 cycles, err_o pulse.
// - rst asserted in BUSY, ack 2 cycles later -> all outputs 0, no write-back, FSM IDLE.

Source files
------------

// File: rtl/mem_dbus_if_pkg.sv
// Shared constants for the MEM-stage load/store unit: aluop codes, stall
// polarity, bus widths and the MEM FSM state encoding.
package mem_dbus_if_pkg;

  localparam int RegBus = 32;
  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_BUSY,
    MEM_HOLD
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane decode: byte enables, lane-replicated store data,
// extended load data and the misalignment flag for one aluop/address pair.
module mem_lane_align
  import mem_dbus_if_pkg::*;
(
  input  logic [7:0]        aluop,
  input  logic [1:0]        addr,
  input  logic [RegBus-1:0] store_data,
  input  logic [RegBus-1:0] load_word,
  output logic              is_mem,
  output logic              is_store,
  output logic              misaligned,
  output logic [3:0]        sel,
  output logic [RegBus-1:0] wdata,
  output logic [RegBus-1:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane 00 is the most significant byte on this bus.
  always_comb begin
    lane_b = load_word[7:0];
    case (addr)
      2'b00:   lane_b = load_word[31:24];
      2'b01:   lane_b = load_word[23:16];
      2'b10:   lane_b = load_word[15:8];
      default: lane_b = load_word[7:0];
    endcase
  end

  assign lane_h = addr[1] ? load_word[15:0] : load_word[31:16];

  always_comb begin
    is_mem     = 1'b1;
    is_store   = 1'b0;
    misaligned = 1'b0;
    sel        = 4'b0000;
    wdata      = ZeroWord;
    load_data  = ZeroWord;
    case (aluop)
      EXE_LB_OP: begin
        sel       = 4'b1000 >> addr;
        load_data = {{24{lane_b[7]}}, lane_b};
      end
      EXE_LBU_OP: begin
        sel       = 4'b1000 >> addr;
        load_data = {24'h0, lane_b};
      end
      EXE_LH_OP: begin
        sel        = addr[1] ? 4'b0011 : 4'b1100;
        misaligned = addr[0];
        load_data  = {{16{lane_h[15]}}, lane_h};
      end
      EXE_LHU_OP: begin
        sel        = addr[1] ? 4'b0011 : 4'b1100;
        misaligned = addr[0];
        load_data  = {16'h0, lane_h};
      end
      EXE_LW_OP: begin
        sel        = 4'b1111;
        misaligned = |addr;
        load_data  = load_word;
      end
      EXE_SB_OP: begin
        is_store = 1'b1;
        sel      = 4'b1000 >> addr;
        wdata    = {4{store_data[7:0]}};
      end
      EXE_SH_OP: begin
        is_store   = 1'b1;
        sel        = addr[1] ? 4'b0011 : 4'b1100;
        misaligned = addr[0];
        wdata      = {2{store_data[15:0]}};
      end
      EXE_SW_OP: begin
        is_store   = 1'b1;
        sel        = 4'b1111;
        misaligned = |addr;
        wdata      = store_data;
      end
      default: is_mem = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_dbus_if.sv
// MEM-stage load/store unit: issues one registered req/ack data-bus access per
// memory instruction, stalls the pipeline until ack and returns extended load data.
module mem_dbus_if
  import mem_dbus_if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TO_MAX = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [RegBus-1:0] wdata_i,
  input  logic [7:0]        aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [RegBus-1:0] reg2_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [RegBus-1:0] wdata_o,
  output logic              stallreq_o,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [ADDR_W-1:0] dbus_addr_o,
  output logic [3:0]        dbus_sel_o,
  output logic [RegBus-1:0] dbus_wdata_o,
  input  logic [RegBus-1:0] dbus_rdata_i,
  input  logic              dbus_ack_i,
  output logic              err_o
);

  localparam int CNT_W = (TO_MAX < 2) ? 1 : $clog2(TO_MAX + 1);

  mem_state_t        state, state_nxt;
  logic [7:0]        op_q;
  logic [1:0]        addr_q;
  logic [RegBus-1:0] rbuf;
  logic [CNT_W-1:0]  to_cnt;
  logic              issue, done, timeout;
  logic              stall_unused;

  logic [7:0]        al_op;
  logic [1:0]        al_addr;
  logic [RegBus-1:0] al_word;
  logic              al_mem, al_store, al_mis;
  logic [3:0]        al_sel;
  logic [RegBus-1:0] al_wdata, al_load;

  assign stall_unused = ^{stall[5], stall[3:0]};

  // One decoder serves both paths: live inputs when issuing, the latched op once in flight.
  assign al_op   = (state == MEM_IDLE) ? aluop_i : op_q;
  assign al_addr = (state == MEM_IDLE) ? mem_addr_i[1:0] : addr_q;
  assign al_word = (state == MEM_HOLD) ? rbuf : dbus_rdata_i;

  assign timeout = (TO_MAX != 0) && (to_cnt == CNT_W'(TO_MAX - 1));

  mem_lane_align u_align (
    .aluop      (al_op),
    .addr       (al_addr),
    .store_data (reg2_i),
    .load_word  (al_word),
    .is_mem     (al_mem),
    .is_store   (al_store),
    .misaligned (al_mis),
    .sel        (al_sel),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= MEM_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    done       = 1'b0;
    stallreq_o = 1'b0;
    err_o      = 1'b0;
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    if (rst) begin
      wd_o    = 5'd0;
      wreg_o  = 1'b0;
      wdata_o = ZeroWord;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (al_mem && al_mis) begin
            err_o  = 1'b1;
            wreg_o = 1'b0;
          end else if (al_mem) begin
            issue      = 1'b1;
            stallreq_o = 1'b1;
            wreg_o     = 1'b0;
            wdata_o    = ZeroWord;
            state_nxt  = MEM_BUSY;
          end
        end
        MEM_BUSY: begin
          // Ack beats a simultaneous timeout: the data is already on the bus.
          if (dbus_ack_i) begin
            done      = 1'b1;
            wreg_o    = wreg_i & ~al_store;
            wdata_o   = al_store ? wdata_i : al_load;
            state_nxt = (stall[4] == Stop) ? MEM_HOLD : MEM_IDLE;
          end else if (timeout) begin
            done      = 1'b1;
            err_o     = 1'b1;
            wreg_o    = 1'b0;
            state_nxt = MEM_IDLE;
          end else begin
            stallreq_o = 1'b1;
            wreg_o     = 1'b0;
            wdata_o    = ZeroWord;
          end
        end
        MEM_HOLD: begin
          wreg_o  = wreg_i & ~al_store;
          wdata_o = al_store ? wdata_i : al_load;
          if (stall[4] == NoStop) state_nxt = MEM_IDLE;
        end
        default: state_nxt = MEM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_sel_o   <= 4'b0000;
      dbus_wdata_o <= ZeroWord;
      op_q         <= 8'h00;
      addr_q       <= 2'b00;
      rbuf         <= ZeroWord;
      to_cnt       <= '0;
    end else if (issue) begin
      dbus_req_o   <= 1'b1;
      dbus_we_o    <= al_store;
      dbus_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
      dbus_sel_o   <= al_sel;
      dbus_wdata_o <= al_store ? al_wdata : ZeroWord;
      op_q         <= aluop_i;
      addr_q       <= mem_addr_i[1:0];
      to_cnt       <= '0;
    end else if (done) begin
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_sel_o   <= 4'b0000;
      dbus_wdata_o <= ZeroWord;
      to_cnt       <= '0;
      if (dbus_ack_i) rbuf <= dbus_rdata_i;
    end else if (state == MEM_BUSY) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_dbus_if.sv
// Scoreboard bench for mem_dbus_if: directed load/store vectors feed expectation
// queues that a negedge monitor pops on each bus request and each completion.
module tb_mem_dbus_if;
  import mem_dbus_if_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_sel_o;
  logic [31:0] dbus_wdata_o;
  logic [31:0] dbus_rdata_i;
  logic        dbus_ack_i;
  logic        err_o;

  mem_dbus_if #(.ADDR_W(32), .TO_MAX(TO)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdata;
  } req_exp_t;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        err;
    int          cyc;
  } wb_exp_t;

  req_exp_t req_q[$];
  wb_exp_t  wb_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Bus slave: acks after ack_wait wait cycles (-1 = never); idle rdata is junk
  int          ack_wait = 0;
  logic [31:0] rd_word  = '0;
  bit          slave_en = 1'b1;
  int          w_cnt    = 0;
  bit          acked    = 1'b0;

  always @(posedge clk) begin
    #1;
    if (slave_en) begin
      dbus_ack_i   = 1'b0;
      dbus_rdata_i = 32'hDEADBEEF;
      if (!dbus_req_o) begin
        acked = 1'b0;
        w_cnt = 0;
      end else if (!acked && ack_wait >= 0) begin
        if (w_cnt == ack_wait) begin
          dbus_ack_i   = 1'b1;
          dbus_rdata_i = rd_word;
          acked        = 1'b1;
        end else begin
          w_cnt++;
        end
      end
    end
  end

  // Monitor: checks each new request and each completion (ack or err) against the queues
  int   stall_cyc = 0;
  int   req_cyc   = 0;
  logic req_prev  = 1'b0;

  always @(negedge clk) begin
    req_exp_t re;
    wb_exp_t  we;
    if (rst) begin
      stall_cyc = 0;
      req_cyc   = 0;
      req_prev  = dbus_req_o;
    end else begin
      if (stallreq_o === 1'b1) stall_cyc++;
      if (dbus_req_o === 1'b1) req_cyc++;
      if (dbus_req_o === 1'b1 && req_prev !== 1'b1) begin
        if (req_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_req: addr 0x%08h sel %b, expected no request", dbus_addr_o, dbus_sel_o);
        end else begin
          re = req_q.pop_front();
          checkOutput("req_addr",  dbus_addr_o,        re.addr);
          checkOutput("req_sel",   32'(dbus_sel_o),    32'(re.sel));
          checkOutput("req_we",    32'(dbus_we_o),     32'(re.we));
          checkOutput("req_wdata", dbus_wdata_o,       re.wdata);
        end
      end
      req_prev = dbus_req_o;
      if ((dbus_req_o === 1'b1 && dbus_ack_i === 1'b1) || err_o === 1'b1) begin
        if (wb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_completion: err %b wreg %b, expected none", err_o, wreg_o);
        end else begin
          we = wb_q.pop_front();
          checkOutput("wb_wd",       32'(wd_o),       32'(we.wd));
          checkOutput("wb_wreg",     32'(wreg_o),     32'(we.wreg));
          checkOutput("wb_err",      32'(err_o),      32'(we.err));
          checkOutput("wb_stallreq", 32'(stallreq_o), 32'd0);
          checkOutput("stall_cycles", 32'(stall_cyc), 32'(we.cyc));
          checkOutput("req_cycles",   32'(req_cyc),   32'(we.cyc));
          if (we.wreg) checkOutput("wb_wdata", wdata_o, we.wdata);
        end
        stall_cyc = 0;
        req_cyc   = 0;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                               input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    aluop_i    = op;
    mem_addr_i = addr;
    reg2_i     = reg2;
    wd_i       = wd;
    wreg_i     = wreg;
    wdata_i    = wdata;
  endtask

  task automatic runTxn(input string name, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [4:0] wd, input int wait_n,
                        input logic [31:0] rd, input bit has_req, input logic [3:0] sel,
                        input logic bus_we, input logic [31:0] bus_wdata, input logic exp_wreg,
                        input logic [31:0] exp_wdata, input logic exp_err, input int exp_cyc,
                        input bit hold);
    bit got = 1'b0;
    ack_wait = wait_n;
    rd_word  = rd;
    if (has_req) req_q.push_back('{{addr[31:2], 2'b00}, sel, bus_we, bus_wdata});
    wb_q.push_back('{wd, exp_wreg, exp_wdata, exp_err, exp_cyc});
    applyStimulus(op, addr, reg2, wd, 1'b1, 32'h0000_AB00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((dbus_req_o === 1'b1 && dbus_ack_i === 1'b1) || err_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s_done: no completion within 20 cycles, expected one", name);
    end
    if (hold) begin
      #1 stall = 6'b010000;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput({name, "_hold1_wdata"},    wdata_o,          exp_wdata);
      checkOutput({name, "_hold1_stallreq"}, 32'(stallreq_o),  32'd0);
      checkOutput({name, "_hold1_req"},      32'(dbus_req_o),  32'd0);
      @(posedge clk); #1 stall = 6'b000000;
      @(negedge clk);
      checkOutput({name, "_hold2_wdata"},    wdata_o,          exp_wdata);
      checkOutput({name, "_hold2_wreg"},     32'(wreg_o),      32'd1);
    end
    @(posedge clk); #1;
    applyStimulus(8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    stall        = 6'b000000;
    dbus_ack_i   = 1'b0;
    dbus_rdata_i = 32'hDEADBEEF;
    applyStimulus(8'h00, 32'h0, 32'h0, 5'd5, 1'b1, 32'h55);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_wd",       32'(wd_o),       32'd0);
    checkOutput("rst_wreg",     32'(wreg_o),     32'd0);
    checkOutput("rst_wdata",    wdata_o,         32'd0);
    checkOutput("rst_req",      32'(dbus_req_o), 32'd0);
    checkOutput("rst_sel",      32'(dbus_sel_o), 32'd0);
    checkOutput("rst_stallreq", 32'(stallreq_o), 32'd0);
    checkOutput("rst_err",      32'(err_o),      32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("nop_wd",    32'(wd_o),   32'd5);
    checkOutput("nop_wreg",  32'(wreg_o), 32'd1);
    checkOutput("nop_wdata", wdata_o,     32'h55);

    applyStimulus(8'b0010_0000, 32'h104, 32'h0, 5'd7, 1'b1, 32'h1234ABCD);
    @(negedge clk);
    checkOutput("alu_wd",       32'(wd_o),       32'd7);
    checkOutput("alu_wdata",    wdata_o,         32'h1234ABCD);
    checkOutput("alu_stallreq", 32'(stallreq_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("alu_req", 32'(dbus_req_o), 32'd0);
    @(posedge clk); #1;

    //     name        op          addr        reg2          wd  wt rdata         rq sel      we bus_wdata     wreg exp_wdata     err cyc hold
    runTxn("lw_w0",    EXE_LW_OP,  32'h100, 32'h0,        3,  0, 32'h12345678, 1, 4'b1111, 0, 32'h0,        1, 32'h12345678, 0, 1, 0);
    runTxn("lb_neg",   EXE_LB_OP,  32'h103, 32'h0,        4,  1, 32'h000000F0, 1, 4'b0001, 0, 32'h0,        1, 32'hFFFFFFF0, 0, 2, 0);
    runTxn("lbu",      EXE_LBU_OP, 32'h103, 32'h0,        5,  0, 32'h000000F0, 1, 4'b0001, 0, 32'h0,        1, 32'h000000F0, 0, 1, 0);
    runTxn("lh_hi",    EXE_LH_OP,  32'h100, 32'h0,        6,  0, 32'h80011234, 1, 4'b1100, 0, 32'h0,        1, 32'hFFFF8001, 0, 1, 0);
    runTxn("lhu_lo",   EXE_LHU_OP, 32'h102, 32'h0,        7,  0, 32'h8001F234, 1, 4'b0011, 0, 32'h0,        1, 32'h0000F234, 0, 1, 0);
    runTxn("lb_lane1", EXE_LB_OP,  32'h101, 32'h0,        8,  0, 32'h11A53344, 1, 4'b0100, 0, 32'h0,        1, 32'hFFFFFFA5, 0, 1, 0);
    runTxn("sh",       EXE_SH_OP,  32'h102, 32'hAAAA5678, 9,  0, 32'h0,        1, 4'b0011, 1, 32'h56785678, 0, 32'h0,        0, 1, 0);
    runTxn("sb_w2",    EXE_SB_OP,  32'h101, 32'h123456C3, 10, 2, 32'h0,        1, 4'b0100, 1, 32'hC3C3C3C3, 0, 32'h0,        0, 3, 0);
    runTxn("sw",       EXE_SW_OP,  32'h204, 32'hCAFEF00D, 11, 0, 32'h0,        1, 4'b1111, 1, 32'hCAFEF00D, 0, 32'h0,        0, 1, 0);
    runTxn("lw_hold",  EXE_LW_OP,  32'h300, 32'h0,        12, 3, 32'h0BADF00D, 1, 4'b1111, 0, 32'h0,        1, 32'h0BADF00D, 0, 4, 1);
    runTxn("lw_mis",   EXE_LW_OP,  32'h101, 32'h0,        13, 0, 32'h0,        0, 4'b0000, 0, 32'h0,        0, 32'h0,        1, 0, 0);
    runTxn("sh_mis",   EXE_SH_OP,  32'h103, 32'h1111,     14, 0, 32'h0,        0, 4'b0000, 0, 32'h0,        0, 32'h0,        1, 0, 0);
    runTxn("lw_tmo",   EXE_LW_OP,  32'h400, 32'h0,        15, -1, 32'h0,       1, 4'b1111, 0, 32'h0,        0, 32'h0,        1, TO, 0);

    // Reset while BUSY, then a stray ack two cycles after reset is raised
    slave_en   = 1'b0;
    dbus_ack_i = 1'b0;
    req_q.push_back('{32'h500, 4'b1111, 1'b0, 32'h0});
    applyStimulus(EXE_LW_OP, 32'h500, 32'h0, 5'd6, 1'b1, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("busy_req",      32'(dbus_req_o), 32'd1);
    checkOutput("busy_stallreq", 32'(stallreq_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus(8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_req", 32'(dbus_req_o), 32'd0);
    @(posedge clk); #1;
    dbus_ack_i   = 1'b1;
    dbus_rdata_i = 32'h77777777;
    @(negedge clk);
    checkOutput("late_ack_req",      32'(dbus_req_o), 32'd0);
    checkOutput("late_ack_stallreq", 32'(stallreq_o), 32'd0);
    checkOutput("late_ack_wreg",     32'(wreg_o),     32'd0);
    checkOutput("late_ack_wdata",    wdata_o,         32'd0);
    checkOutput("late_ack_err",      32'(err_o),      32'd0);
    @(posedge clk); #1;
    dbus_ack_i   = 1'b0;
    dbus_rdata_i = 32'hDEADBEEF;
    slave_en     = 1'b1;
    @(negedge clk);
    checkOutput("after_ack_req", 32'(dbus_req_o), 32'd0);
    @(posedge clk); #1;

    checkOutput("req_queue_left", 32'(req_q.size()), 32'd0);
    checkOutput("wb_queue_left",  32'(wb_q.size()),  32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
